mem_arbiter_unit: RTL and testbench
===================================

Name: mem_arbiter_unit

Overview:
- Arbitrates a single shared memory port between instruction fetch (IF) and load/store (LS) requesters in the RISC-V core.
- Sits between the fetch/PC stage, the LSU and the unified memory. Gated by the reset control unit's feeding-state enable.
- Sequences each transaction through a req/ready handshake.
- LS has fixed priority, with a starvation guard for IF.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is waiting (must be >= 1)
TIMEOUT_CYC, 64, cycles allowed for MAU_Mem_Ready (used only with MAU_TIMEOUT_EN)

Ports:
MAU_Clk  in  1  clock, rising edge
MAU_Reset  in  1  asynchronous active-low reset
MAU_Enable  in  1  arbitration enable, driven from the RCU instruction-memory-read output
MAU_If_Req  in  1  fetch request, level
MAU_If_Addr  in  ADDR_W  fetch address
MAU_If_Ack  out  1  one-cycle fetch completion pulse
MAU_If_Rdata  out  DATA_W  fetch data, valid while MAU_If_Ack is high
MAU_Ls_Req  in  1  load/store request, level
MAU_Ls_We  in  1  1=store, 0=load
MAU_Ls_Addr  in  ADDR_W  LS address
MAU_Ls_Wdata  in  DATA_W  store data
MAU_Ls_Be  in  DATA_W/8  byte enables
MAU_Ls_Ack  out  1  one-cycle LS completion pulse
MAU_Ls_Rdata  out  DATA_W  load data, valid while MAU_Ls_Ack is high
MAU_Mem_Req  out  1  memory request
MAU_Mem_We  out  1  memory write enable
MAU_Mem_Addr  out  ADDR_W  memory address
MAU_Mem_Wdata  out  DATA_W  memory write data
MAU_Mem_Be  out  DATA_W/8  memory byte enables
MAU_Mem_Rdata  in  DATA_W  memory read data, sampled when MAU_Mem_Ready is high
MAU_Mem_Ready  in  1  memory completion
MAU_Stall  out  1  combinational: MAU_If_Req & ~MAU_If_Ack (PC hold)

Behaviour:
- Reset (async, MAU_Reset=0):
  - FSM goes to IDLE; streak counter cleared.
  - All registered outputs are 0: Mem_Req, Mem_We, Mem_Addr, Mem_Wdata, Mem_Be, both Acks, both Rdatas.
  - Reset mid-transaction abandons it; no Ack is issued.
- Requesters hold Req and payload stable until their Ack. Req is sampled only in IDLE.
- FSM states: IDLE, BUSY_IF, BUSY_LS, RESP.
- IDLE, if MAU_Enable=1 and any Req is high:
  - Grant LS if MAU_Ls_Req=1, unless MAU_If_Req=1 and streak==MAX_LS_STREAK; in that case grant IF.
  - Otherwise grant IF if MAU_If_Req=1.
  - Capture the granted payload into the Mem_* registers. IF grant drives We=0 and Be=all ones.
  - Assert MAU_Mem_Req from the next cycle.
  - If MAU_Enable=0, no grant; stay in IDLE.
- BUSY_x:
  - Mem_Req and payload are held constant.
  - On the first cycle with MAU_Mem_Ready=1: register Mem_Rdata into x_Rdata, drop Mem_Req, go to RESP.
- RESP:
  - x_Ack=1 for exactly one cycle, then back to IDLE.
  - x_Rdata holds its value until the next Ack for the same requester.
  - For stores, Ls_Rdata is unchanged.
- Latency: Req sampled in cycle N -> Mem_Req at N+1 -> Ack at N+2 if Ready in N+1 (minimum 3 cycles per transaction). Each wait cycle adds 1.
- Streak counter:
  - Increments (saturating at MAX_LS_STREAK) on an LS grant while MAU_If_Req=1.
  - Clears on any IF grant.
  - Clears on an LS grant while MAU_If_Req=0.
- MAU_Enable falling mid-transaction: the current transaction completes normally; no new grant is made.
- MAU_Mem_Ready while not in BUSY is ignored.
- A requester keeping Req high after its Ack starts a new transaction at the next IDLE arbitration.

Optional Feature:
- Macro MAU_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in BUSY_x.
  - If it reaches TIMEOUT_CYC with no MAU_Mem_Ready, drop Mem_Req, go to RESP, pulse x_Ack with x_Rdata=0, and set a sticky output port MAU_Err (1 bit).
  - MAU_Err clears only on reset.
- Without the macro: no counter and no MAU_Err port; BUSY waits indefinitely.

Test Plan:
1. IF-only fetch: If_Req=1, If_Addr=0x100, Ready returned in the same cycle as Mem_Req with Rdata=0x00500093 -> Mem_Addr=0x100, We=0, Be=0xF; If_Ack one cycle, 2 cycles after Req, with If_Rdata=0x00500093.
2. Store with wait states: Ls_We=1, Addr=0x2000, Wdata=0xDEADBEEF, Be=0x3, Ready delayed 3 cycles -> Mem payload stable all 4 BUSY cycles; Ls_Ack 1 cycle after Ready; Ls_Rdata unchanged.
3. Simultaneous requests: both Req high in the same IDLE cycle, streak=0 -> LS granted first; IF granted next; MAU_Stall high until If_Ack.
4. Starvation: If_Req held, Ls_Req held continuously, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS...
5. Reset mid-BUSY_LS: assert MAU_Reset=0 asynchronously -> all outputs 0 immediately; no Ack; streak=0; first grant after release follows a fresh arbitration.
6. MAU_TIMEOUT_EN, TIMEOUT_CYC=8, Ready held low -> Mem_Req drops after 8 BUSY cycles; If_Ack pulses with If_Rdata=0; MAU_Err=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_arbiter_unit_if.sv
// mem_arbiter_unit_if: groups the signals of the shared memory-port arbiter.
//   slave  modport : seen by the arbiter (requests/memory status in, grants/acks out)
//   master modport : seen by the environment (fetch stage, LSU, memory, RCU)
// Signals:
//   MAU_Enable                          arbitration enable from the RCU
//   MAU_If_Req/Addr, MAU_If_Ack/Rdata   instruction-fetch requester
//   MAU_Ls_Req/We/Addr/Wdata/Be,
//   MAU_Ls_Ack/Rdata                    load/store requester
//   MAU_Mem_Req/We/Addr/Wdata/Be,
//   MAU_Mem_Rdata/Ready                 unified memory port
//   MAU_Stall                           PC hold for the fetch stage
//   MAU_Err                             sticky memory-timeout flag (only with MAU_TIMEOUT_EN)
interface mem_arbiter_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  MAU_Enable;
  logic                  MAU_If_Req;
  logic [ADDR_W-1:0]     MAU_If_Addr;
  logic                  MAU_If_Ack;
  logic [DATA_W-1:0]     MAU_If_Rdata;
  logic                  MAU_Ls_Req;
  logic                  MAU_Ls_We;
  logic [ADDR_W-1:0]     MAU_Ls_Addr;
  logic [DATA_W-1:0]     MAU_Ls_Wdata;
  logic [DATA_W/8-1:0]   MAU_Ls_Be;
  logic                  MAU_Ls_Ack;
  logic [DATA_W-1:0]     MAU_Ls_Rdata;
  logic                  MAU_Mem_Req;
  logic                  MAU_Mem_We;
  logic [ADDR_W-1:0]     MAU_Mem_Addr;
  logic [DATA_W-1:0]     MAU_Mem_Wdata;
  logic [DATA_W/8-1:0]   MAU_Mem_Be;
  logic [DATA_W-1:0]     MAU_Mem_Rdata;
  logic                  MAU_Mem_Ready;
  logic                  MAU_Stall;
`ifdef MAU_TIMEOUT_EN
  logic                  MAU_Err;
`endif

  modport slave (
`ifdef MAU_TIMEOUT_EN
    output MAU_Err,
`endif
    input  MAU_Enable,
    input  MAU_If_Req, MAU_If_Addr,
    output MAU_If_Ack, MAU_If_Rdata,
    input  MAU_Ls_Req, MAU_Ls_We, MAU_Ls_Addr, MAU_Ls_Wdata, MAU_Ls_Be,
    output MAU_Ls_Ack, MAU_Ls_Rdata,
    output MAU_Mem_Req, MAU_Mem_We, MAU_Mem_Addr, MAU_Mem_Wdata, MAU_Mem_Be,
    input  MAU_Mem_Rdata, MAU_Mem_Ready,
    output MAU_Stall
  );

  modport master (
`ifdef MAU_TIMEOUT_EN
    input  MAU_Err,
`endif
    output MAU_Enable,
    output MAU_If_Req, MAU_If_Addr,
    input  MAU_If_Ack, MAU_If_Rdata,
    output MAU_Ls_Req, MAU_Ls_We, MAU_Ls_Addr, MAU_Ls_Wdata, MAU_Ls_Be,
    input  MAU_Ls_Ack, MAU_Ls_Rdata,
    input  MAU_Mem_Req, MAU_Mem_We, MAU_Mem_Addr, MAU_Mem_Wdata, MAU_Mem_Be,
    output MAU_Mem_Rdata, MAU_Mem_Ready,
    input  MAU_Stall
  );
endinterface

// File: rtl/mem_arbiter_unit.sv
// mem_arbiter_unit: arbitrates one shared memory port between instruction
// fetch (IF) and load/store (LS). LS has fixed priority, but after
// MAX_LS_STREAK consecutive LS grants while IF waits, IF wins one round.
// Each transaction is IDLE -> BUSY_x -> RESP (Ack pulse) -> IDLE.
// Ports:
//   MAU_Clk    rising-edge clock
//   MAU_Reset  asynchronous active-low reset
//   bus        mem_arbiter_unit_if.slave (requesters, memory port, stall, err)
// Optional feature: define MAU_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYC cycles without MAU_Mem_Ready (Ack with zero data, sticky MAU_Err).
module mem_arbiter_unit #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic              MAU_Clk,
  input  logic              MAU_Reset,
  mem_arbiter_unit_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_LS_STREAK + 1);

  if (MAX_LS_STREAK < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_arbiter_unit: MAX_LS_STREAK and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_be;
  logic                r_if_ack;
  logic                r_ls_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                w_grant_ls;
  logic                w_grant_if;
  logic                w_done;
  logic                w_to_fire;
  logic                w_to_hit;
  logic                w_streak_full;

  // IF is owed a turn once LS has won MAX_LS_STREAK times in a row while IF waited.
  assign w_streak_full = (r_streak == SW'(MAX_LS_STREAK));

`ifdef MAU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // Counter value TIMEOUT_CYC-1 marks the last BUSY cycle allowed.
  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // Timeout counter runs while BUSY; error flag is sticky until reset.
  always_ff @(posedge MAU_Clk or negedge MAU_Reset) begin
    if (!MAU_Reset) begin
      r_to_cnt <= {TW{1'b0}};
      r_err    <= 1'b0;
    end else begin
      if ((r_state == ST_BUSY_IF || r_state == ST_BUSY_LS) && !bus.MAU_Mem_Ready) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= {TW{1'b0}};
      end
      if (w_to_fire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.MAU_Err = r_err;
`else
  assign w_to_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge MAU_Clk or negedge MAU_Reset) begin
    if (!MAU_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_ls  = 1'b0;
    w_grant_if  = 1'b0;
    w_done      = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.MAU_Enable && bus.MAU_Ls_Req && !(bus.MAU_If_Req && w_streak_full)) begin
          w_grant_ls  = 1'b1;
          w_state_nxt = ST_BUSY_LS;
        end else if (bus.MAU_Enable && bus.MAU_If_Req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_BUSY_IF;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_IF, ST_BUSY_LS: begin
        if (bus.MAU_Mem_Ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_to_fire   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory payload capture, streak tracking, response data and Ack pulses.
  always_ff @(posedge MAU_Clk or negedge MAU_Reset) begin
    if (!MAU_Reset) begin
      r_streak    <= {SW{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_mem_be    <= {BE_W{1'b0}};
      r_if_ack    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_ls_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      if (w_grant_ls) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.MAU_Ls_We;
        r_mem_addr  <= bus.MAU_Ls_Addr;
        r_mem_wdata <= bus.MAU_Ls_Wdata;
        r_mem_be    <= bus.MAU_Ls_Be;
        // Streak only grows while IF is actually being made to wait.
        if (!bus.MAU_If_Req) begin
          r_streak <= {SW{1'b0}};
        end else if (!w_streak_full) begin
          r_streak <= r_streak + SW'(1);
        end
      end else if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.MAU_If_Addr;
        r_mem_wdata <= {DATA_W{1'b0}};
        r_mem_be    <= {BE_W{1'b1}};
        r_streak    <= {SW{1'b0}};
      end else if (w_done || w_to_fire) begin
        r_mem_req <= 1'b0;
        // A timed-out access returns zero data to its owner.
        if (r_state == ST_BUSY_IF) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_done ? bus.MAU_Mem_Rdata : {DATA_W{1'b0}};
        end else begin
          r_ls_ack <= 1'b1;
          if (!r_mem_we) begin
            r_ls_rdata <= w_done ? bus.MAU_Mem_Rdata : {DATA_W{1'b0}};
          end
        end
      end
    end
  end

  assign bus.MAU_Mem_Req   = r_mem_req;
  assign bus.MAU_Mem_We    = r_mem_we;
  assign bus.MAU_Mem_Addr  = r_mem_addr;
  assign bus.MAU_Mem_Wdata = r_mem_wdata;
  assign bus.MAU_Mem_Be    = r_mem_be;
  assign bus.MAU_If_Ack    = r_if_ack;
  assign bus.MAU_Ls_Ack    = r_ls_ack;
  assign bus.MAU_If_Rdata  = r_if_rdata;
  assign bus.MAU_Ls_Rdata  = r_ls_rdata;
  // PC hold: fetch pending and not completing this cycle.
  assign bus.MAU_Stall     = bus.MAU_If_Req & ~r_if_ack;
endmodule

// File: tb/tb_mem_arbiter_unit.sv
// tb_mem_arbiter_unit: directed bench for mem_arbiter_unit with a
// transaction-level reference model checked every cycle.
module tb_mem_arbiter_unit;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arbiter_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter_unit #(
    .ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(MAXS), .TIMEOUT_CYC(TO)
  ) dut (
    .MAU_Clk(clk),
    .MAU_Reset(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int          delay = 0;
  int          rcnt = 0;
  bit          stray = 1'b0;
  logic [31:0] rdata_val = 32'h0;

  initial begin
    bus.MAU_Mem_Ready = 1'b0;
    bus.MAU_Mem_Rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.MAU_Mem_Ready = 1'b0;
        rcnt = 0;
      end else if (bus.MAU_Mem_Req) begin
        bus.MAU_Mem_Ready = (rcnt == delay);
        bus.MAU_Mem_Rdata = (rcnt == delay) ? rdata_val : 32'hBAD0BAD0;
        rcnt++;
      end else begin
        bus.MAU_Mem_Ready = stray;
        bus.MAU_Mem_Rdata = 32'hBAD0BAD0;
        rcnt = 0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;
  grant_t glog[$];

  bit          m_open, m_ls, m_we, m_ack_ls, m_err, prev_req;
  int          m_grant, m_done, m_ack_cyc, m_free_from, m_streak;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_ls_rd;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_open = 1'b0; m_err = 1'b0; prev_req = 1'b0;
      m_streak = 0; m_free_from = 0; m_ack_cyc = -1; m_done = -1;
      m_if_rd = 32'h0; m_ls_rd = 32'h0;
    end else begin
      bit e_req, e_if_ack, e_ls_ack;
      e_req    = m_open && (cyc > m_grant) && (m_done < 0 || cyc <= m_done);
      e_if_ack = (m_ack_cyc == cyc) && !m_ack_ls;
      e_ls_ack = (m_ack_cyc == cyc) && m_ack_ls;
      check("mem_req", {31'd0, bus.MAU_Mem_Req}, {31'd0, e_req});
      check("if_ack", {31'd0, bus.MAU_If_Ack}, {31'd0, e_if_ack});
      check("ls_ack", {31'd0, bus.MAU_Ls_Ack}, {31'd0, e_ls_ack});
      check("if_rdata", bus.MAU_If_Rdata, m_if_rd);
      check("ls_rdata", bus.MAU_Ls_Rdata, m_ls_rd);
      check("stall", {31'd0, bus.MAU_Stall}, {31'd0, bus.MAU_If_Req & ~e_if_ack});
`ifdef MAU_TIMEOUT_EN
      check("err", {31'd0, bus.MAU_Err}, {31'd0, m_err});
`endif
      if (e_req) begin
        check("mem_addr", bus.MAU_Mem_Addr, m_addr);
        check("mem_we", {31'd0, bus.MAU_Mem_We}, {31'd0, m_we});
        check("mem_be", {28'd0, bus.MAU_Mem_Be}, {28'd0, m_be});
        if (m_we) check("mem_wdata", bus.MAU_Mem_Wdata, m_wdata);
      end
      if (bus.MAU_Mem_Req && !prev_req)
        glog.push_back('{bus.MAU_Mem_Addr, bus.MAU_Mem_We, bus.MAU_Mem_Be, bus.MAU_Mem_Wdata});
      prev_req = bus.MAU_Mem_Req;

      // Advance the model with this cycle's inputs.
      if (m_open && m_done < 0 && cyc > m_grant) begin
        if (bus.MAU_Mem_Ready) begin
          m_done = cyc; m_ack_cyc = cyc + 1; m_ack_ls = m_ls;
          if (!m_ls) m_if_rd = bus.MAU_Mem_Rdata;
          else if (!m_we) m_ls_rd = bus.MAU_Mem_Rdata;
        end
`ifdef MAU_TIMEOUT_EN
        else if (cyc == m_grant + TO) begin
          m_done = cyc; m_ack_cyc = cyc + 1; m_ack_ls = m_ls; m_err = 1'b1;
          if (!m_ls) m_if_rd = 32'h0;
          else if (!m_we) m_ls_rd = 32'h0;
        end
`endif
      end else if (m_open && m_done >= 0 && cyc == m_ack_cyc) begin
        m_open = 1'b0;
        m_free_from = cyc + 1;
      end else if (!m_open && cyc >= m_free_from && bus.MAU_Enable &&
                   (bus.MAU_If_Req || bus.MAU_Ls_Req)) begin
        m_open = 1'b1; m_grant = cyc; m_done = -1;
        if (bus.MAU_Ls_Req && !(bus.MAU_If_Req && m_streak == MAXS)) begin
          m_ls = 1'b1; m_we = bus.MAU_Ls_We; m_addr = bus.MAU_Ls_Addr;
          m_wdata = bus.MAU_Ls_Wdata; m_be = bus.MAU_Ls_Be;
          m_streak = bus.MAU_If_Req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else begin
          m_ls = 1'b0; m_we = 1'b0; m_addr = bus.MAU_If_Addr;
          m_wdata = 32'h0; m_be = 4'hF; m_streak = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(input bit ls, input bit drop, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((ls ? bus.MAU_Ls_Ack : bus.MAU_If_Ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_checks++;
    if (at < 0) begin
      n_errors++;
      $display("FAIL ack_wait_%s: got no ack expected ack within 40 cycles", ls ? "ls" : "if");
    end
    if (drop) begin
      if (ls) bus.MAU_Ls_Req = 1'b0;
      else bus.MAU_If_Req = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int i;
    for (i = 0; i < budget && glog.size() < n; i++) @(negedge clk);
    n_checks++;
    if (glog.size() < n) begin
      n_errors++;
      $display("FAIL grant_wait: got %0d grants expected %0d", glog.size(), n);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mreq"}, {31'd0, bus.MAU_Mem_Req}, 32'd0);
    check({tag, "_mwe"}, {31'd0, bus.MAU_Mem_We}, 32'd0);
    check({tag, "_maddr"}, bus.MAU_Mem_Addr, 32'd0);
    check({tag, "_mwdata"}, bus.MAU_Mem_Wdata, 32'd0);
    check({tag, "_mbe"}, {28'd0, bus.MAU_Mem_Be}, 32'd0);
    check({tag, "_ifack"}, {31'd0, bus.MAU_If_Ack}, 32'd0);
    check({tag, "_lsack"}, {31'd0, bus.MAU_Ls_Ack}, 32'd0);
    check({tag, "_ifrd"}, bus.MAU_If_Rdata, 32'd0);
    check({tag, "_lsrd"}, bus.MAU_Ls_Rdata, 32'd0);
`ifdef MAU_TIMEOUT_EN
    check({tag, "_err"}, {31'd0, bus.MAU_Err}, 32'd0);
`endif
  endtask

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int b, c0, at;
    logic [31:0] exp_ord [9];
    rst_n = 1'b0;
    bus.MAU_Enable = 1'b1;
    bus.MAU_If_Req = 1'b0; bus.MAU_If_Addr = 32'h0;
    bus.MAU_Ls_Req = 1'b0; bus.MAU_Ls_We = 1'b0; bus.MAU_Ls_Addr = 32'h0;
    bus.MAU_Ls_Wdata = 32'h0; bus.MAU_Ls_Be = 4'h0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    @(posedge clk); #3 rst_n = 1'b1;

    // 1: IF-only fetch, Ready with Mem_Req.
    b = glog.size(); delay = 0; rdata_val = 32'h00500093;
    at_drive();
    bus.MAU_If_Addr = 32'h100; bus.MAU_If_Req = 1'b1; c0 = cyc;
    wait_ack(1'b0, 1'b1, at);
    check("t1_latency", at, c0 + 2);
    check("t1_rdata", bus.MAU_If_Rdata, 32'h00500093);
    check("t1_addr", glog[b].addr, 32'h100);
    check("t1_be", {28'd0, glog[b].be}, 32'hF);
    check("t1_we", {31'd0, glog[b].we}, 32'd0);

    // 3: simultaneous requests, LS first.
    b = glog.size(); rdata_val = 32'h11112222;
    at_drive();
    bus.MAU_Ls_Addr = 32'h2100; bus.MAU_Ls_We = 1'b0; bus.MAU_Ls_Be = 4'hF;
    bus.MAU_If_Addr = 32'h104; bus.MAU_Ls_Req = 1'b1; bus.MAU_If_Req = 1'b1;
    wait_ack(1'b1, 1'b1, at);
    check("t3_stall", {31'd0, bus.MAU_Stall}, 32'd1);
    check("t3_ls_rdata", bus.MAU_Ls_Rdata, 32'h11112222);
    rdata_val = 32'h33334444;
    wait_ack(1'b0, 1'b1, at);
    check("t3_if_rdata", bus.MAU_If_Rdata, 32'h33334444);
    check("t3_first", glog[b].addr, 32'h2100);
    check("t3_second", glog[b+1].addr, 32'h104);

    // 2: store with 3 wait states.
    b = glog.size(); delay = 3;
    at_drive();
    bus.MAU_Ls_We = 1'b1; bus.MAU_Ls_Addr = 32'h2000; bus.MAU_Ls_Wdata = 32'hDEADBEEF;
    bus.MAU_Ls_Be = 4'h3; bus.MAU_Ls_Req = 1'b1; c0 = cyc;
    wait_ack(1'b1, 1'b1, at);
    check("t2_latency", at, c0 + 5);
    check("t2_ls_rdata_kept", bus.MAU_Ls_Rdata, 32'h11112222);
    check("t2_wdata", glog[b].wdata, 32'hDEADBEEF);
    check("t2_be", {28'd0, glog[b].be}, 32'h3);

    // Enable gating, stray Ready in idle, enable drop mid-transaction.
    b = glog.size(); rdata_val = 32'h55667788; stray = 1'b1;
    at_drive();
    bus.MAU_Enable = 1'b0;
    bus.MAU_Ls_We = 1'b0; bus.MAU_Ls_Addr = 32'h2200; bus.MAU_Ls_Be = 4'hF; bus.MAU_Ls_Req = 1'b1;
    repeat (4) @(negedge clk);
    check("en_no_grant", glog.size(), b);
    at_drive();
    bus.MAU_Enable = 1'b1;
    wait_grants(b + 1, 10);
    bus.MAU_Enable = 1'b0;
    wait_ack(1'b1, 1'b1, at);
    check("en_ls_rdata", bus.MAU_Ls_Rdata, 32'h55667788);
    at_drive();
    bus.MAU_If_Addr = 32'h108; bus.MAU_If_Req = 1'b1;
    repeat (4) @(negedge clk);
    check("en_if_blocked", glog.size(), b + 1);
    at_drive();
    bus.MAU_Enable = 1'b1;
    wait_ack(1'b0, 1'b1, at);
    check("en_if_rdata", bus.MAU_If_Rdata, 32'h55667788);
    stray = 1'b0;

`ifdef MAU_TIMEOUT_EN
    // 6: timeout with Ready held low.
    delay = 1000;
    at_drive();
    bus.MAU_If_Addr = 32'h10C; bus.MAU_If_Req = 1'b1; c0 = cyc;
    wait_ack(1'b0, 1'b1, at);
    check("t6_latency", at, c0 + TO + 1);
    check("t6_rdata", bus.MAU_If_Rdata, 32'h0);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", {31'd0, bus.MAU_Err}, 32'd1);
`endif

    // 4: starvation guard, both held.
    b = glog.size(); delay = 2; rdata_val = 32'h0A0B0C0D;
    at_drive();
    bus.MAU_Ls_We = 1'b0; bus.MAU_Ls_Addr = 32'h3000; bus.MAU_Ls_Be = 4'h1;
    bus.MAU_If_Addr = 32'h200; bus.MAU_Ls_Req = 1'b1; bus.MAU_If_Req = 1'b1;
    wait_grants(b + 9, 120);
    exp_ord = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h200,
                32'h3000, 32'h3000, 32'h3000, 32'h3000};
    for (int i = 0; i < 9; i++) check($sformatf("t4_order%0d", i), glog[b+i].addr, exp_ord[i]);

    // 5: async reset in BUSY_LS; streak must restart.
    #2 rst_n = 1'b0;
    #1 check_zero("t5");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_grants(b + 10, 10);
    check("t5_fresh_grant", glog[b+9].addr, 32'h3000);
    wait_ack(1'b1, 1'b1, at);
    wait_ack(1'b0, 1'b1, at);
    check("t5_if_rdata", bus.MAU_If_Rdata, 32'h0A0B0C0D);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
